dm_bytelane: RTL and testbench
==============================

# dm_bytelane

Parametrised data memory for the pipelined MIPS CPU's MEM stage, and the successor to the fixed 1024-word, word-only data memory. It adds byte and halfword loads and stores with sign or zero extension and little-endian lane selection. It flags misaligned, out-of-range and illegal accesses. After reset it clears the array with a hardware sweep, one word per cycle, and reports `Busy` until the sweep finishes. Every committed store emits the standard simulation write trace.

## Interface
Parameters:
- ADDR_W, 10, word-address width; depth is 2^ADDR_W words of 32 bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- Addr  in  32  byte address from the ALU.
- DataIn  in  32  store data (rt); the low bytes are used for sub-word stores.
- MemWrite  in  1  store request.
- MemOp  in  3  access type: 000 word, 001 half unsigned, 010 half signed, 011 byte unsigned, 100 byte signed; 101–111 illegal.
- PC  in  32  PC of the instruction in MEM; used only for the trace.
- DataOut  out  32  load result, already extended.
- Busy  out  1  high while the clear sweep runs.
- AddrErr  out  1  access fault for the current Addr/MemOp.

## Operation
- The FSM has two states, CLEAR and READY, and a counter `clr_idx[ADDR_W-1:0]`.
- reset=1, asynchronous:
  - state=CLEAR, clr_idx=0, Busy=1.
  - Array contents are not touched asynchronously.
- CLEAR, on each rising edge:
  - mem[clr_idx] <= 0 and clr_idx increments.
  - On the edge where clr_idx==2^ADDR_W−1, state becomes READY.
  - Busy is registered: Busy = (state==CLEAR).
- READY is terminal until the next reset.
- If reset is reasserted mid-sweep or in READY, the sweep restarts from word 0.
- Word index is Addr[ADDR_W+1:2].
- AddrErr = 1 if any of the following hold (combinational, including while Busy):
  - Addr[31:ADDR_W+2] != 0 (out of range);
  - word access with Addr[1:0] != 0;
  - half access with Addr[0] != 0;
  - MemOp is illegal.
- Store commit: on a rising edge with state==READY, MemWrite=1 and AddrErr=0.
  - Word: the whole word is replaced by DataIn.
  - Half: the lane selected by Addr[1] (0 → bits 15:0, 1 → bits 31:16) gets DataIn[15:0]; the other half is kept.
  - Byte: lane Addr[1:0] (bits 8·k+7 : 8·k) gets DataIn[7:0]; the other lanes are kept.
  - MemOp 001/010 are treated identically for stores, as are 011/100.
- Suppressed stores: MemWrite while Busy or while AddrErr=1 commits nothing and prints no trace.
- Load (combinational from the array and the inputs):
  - Word: DataOut is the full word.
  - Half: the selected half, zero-extended (001) or sign-extended (010) to 32 bits.
  - Byte: the selected byte, zero-extended (011) or sign-extended (100).
  - DataOut=0 whenever Busy=1 or AddrErr=1.
- Trace: each committed store prints `@%h: *%h <= %h` with:
  - PC;
  - the word-aligned byte address {Addr[31:2],2'b00};
  - the full post-merge 32-bit word.

## Timing
- Reset values: Busy=1, state=CLEAR, clr_idx=0.
- While Busy=1, DataOut=0 regardless of the array.
- AddrErr is purely combinational and has no reset value.
- Sweep latency: 2^ADDR_W rising edges after reset deasserts. Busy falls just after edge number 2^ADDR_W (1024 edges at the default).
- A store becomes visible at DataOut right after its commit edge.
- On the commit cycle, DataOut still shows the old contents (read-before-write).
- Loads have zero latency: DataOut settles combinationally from Addr, MemOp and the array in the same cycle.
- Store and load to the same word in consecutive cycles: the load sees the merged word with no stall.
- The top level holds the pipeline, or accepts that stores are dropped, while Busy=1. The block itself never stalls.

## Test plan
- Reset sweep, ADDR_W=4:
  - Pulse reset, then release.
  - Busy must be high for exactly 16 edges and low after the 16th.
  - All 16 words must read 0.
  - Reassert reset at edge 7: Busy must stay high for 16 more edges.
- Word store and load:
  - Store sw 0x12345678 @0x10 with PC 0x3000.
  - Trace must print `@00003000: *00000010 <= 12345678`.
  - lw @0x10 must return 0x12345678.
- Byte and half merge:
  - Start from 0x12345678 @0x10.
  - sb DataIn=0xAB @0x11 must give word 0x1234AB78.
  - sh DataIn=0xBEEF @0x12 must give word 0xBEEFAB78.
- Extension:
  - Using word 0xBEEFAB78:
  - lb @0x11 → 0xFFFFFFAB; lbu @0x11 → 0x000000AB.
  - lh @0x12 → 0xFFFFBEEF; lhu @0x12 → 0x0000BEEF.
- Faults:
  - sw @0x12 must give AddrErr=1, no write and no trace.
  - lh @0x13 must give AddrErr=1 and DataOut=0.
  - Any Addr ≥ 2^(ADDR_W+2) must give AddrErr=1.
  - MemOp=110 must give AddrErr=1.
- Busy gating:
  - Issue sw 0xFFFFFFFF @0x0 during the sweep.
  - The store must not commit and must print no trace.
  - Word 0 must read 0 after Busy falls.

Source files
------------

// File: rtl/dm_bytelane.sv
// rtl/dm_bytelane.sv - byte-lane data memory for the MIPS MEM stage
// Clears itself after reset, then serves word/half/byte loads and stores with fault flagging.
module dm_bytelane #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic [31:0] DataIn,
  input  logic        MemWrite,
  input  logic [2:0]  MemOp,
  input  logic [31:0] PC,
  output logic [31:0] DataOut,
  output logic        Busy,
  output logic        AddrErr
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {S_CLEAR = 1'b0, S_READY = 1'b1} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_idx;
  logic [31:0]       r_mem [DEPTH];

  logic [ADDR_W-1:0] w_idx;
  logic              w_is_word;
  logic              w_is_half;
  logic              w_is_byte;
  logic              w_illegal;
  logic              w_oor;
  logic              w_commit;
  logic [31:0]       w_rword;
  logic [31:0]       w_wdata;
  logic [15:0]       w_half;
  logic [7:0]        w_byte;

  assign w_idx     = Addr[ADDR_W+1:2];
  assign w_is_word = (MemOp == 3'b000);
  assign w_is_half = (MemOp == 3'b001) || (MemOp == 3'b010);
  assign w_is_byte = (MemOp == 3'b011) || (MemOp == 3'b100);
  assign w_illegal = (MemOp > 3'b100);
  assign w_oor     = |Addr[31:ADDR_W+2];

  assign AddrErr = w_oor || w_illegal
                || (w_is_word && (Addr[1:0] != 2'b00))
                || (w_is_half && Addr[0]);

  assign w_commit = (r_state == S_READY) && MemWrite && !AddrErr;

  assign w_rword = r_mem[w_idx];
  assign w_half  = Addr[1] ? w_rword[31:16] : w_rword[15:0];

  always_comb begin
    w_byte = w_rword[7:0];
    case (Addr[1:0])
      2'd0: w_byte = w_rword[7:0];
      2'd1: w_byte = w_rword[15:8];
      2'd2: w_byte = w_rword[23:16];
      2'd3: w_byte = w_rword[31:24];
      default: w_byte = w_rword[7:0];
    endcase
  end

  // Store merge: only the addressed lane changes, the rest of the word is kept
  always_comb begin
    w_wdata = w_rword;
    if (w_is_word) begin
      w_wdata = DataIn;
    end else if (w_is_half) begin
      if (Addr[1]) w_wdata[31:16] = DataIn[15:0];
      else         w_wdata[15:0]  = DataIn[15:0];
    end else if (w_is_byte) begin
      case (Addr[1:0])
        2'd0: w_wdata[7:0]   = DataIn[7:0];
        2'd1: w_wdata[15:8]  = DataIn[7:0];
        2'd2: w_wdata[23:16] = DataIn[7:0];
        2'd3: w_wdata[31:24] = DataIn[7:0];
        default: w_wdata = w_rword;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_CLEAR) r_clr_idx <= r_clr_idx + ADDR_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == S_CLEAR) && (r_clr_idx == {ADDR_W{1'b1}})) w_state_nxt = S_READY;
  end

  always_comb begin
    Busy    = (r_state == S_CLEAR);
    DataOut = 32'h0;
    if (!Busy && !AddrErr) begin
      case (MemOp)
        3'b000:  DataOut = w_rword;
        3'b001:  DataOut = {16'h0, w_half};
        3'b010:  DataOut = {{16{w_half[15]}}, w_half};
        3'b011:  DataOut = {24'h0, w_byte};
        3'b100:  DataOut = {{24{w_byte[7]}}, w_byte};
        default: DataOut = 32'h0;
      endcase
    end
  end

  // Array has no reset: the sweep zeroes it, so the asynchronous reset never touches it
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) r_mem[r_clr_idx] <= 32'h0;
    else if (w_commit)      r_mem[w_idx]     <= w_wdata;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (w_commit) $display("@%h: *%h <= %h", PC, {Addr[31:2], 2'b00}, w_wdata);
  end
`endif

endmodule

// File: tb/tb_dm_bytelane.sv
// tb/tb_dm_bytelane.sv - scoreboard bench for dm_bytelane
// Stimulus pushes expected outputs and commits; negedge monitors pop and compare.
module tb_dm_bytelane;

  logic        clk;
  logic        reset;
  logic [31:0] Addr;
  logic [31:0] DataIn;
  logic        MemWrite;
  logic [2:0]  MemOp;
  logic [31:0] PC;
  logic [31:0] DataOut;
  logic        Busy;
  logic        AddrErr;

  dm_bytelane #(.ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .DataIn(DataIn), .MemWrite(MemWrite),
    .MemOp(MemOp), .PC(PC), .DataOut(DataOut), .Busy(Busy), .AddrErr(AddrErr)
  );

  typedef struct {
    string       name;
    logic [31:0] data;
    logic        err;
    logic        busy;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] word;
  } trc_t;

  exp_t q_ld[$];
  trc_t q_tr[$];
  logic rd_chk;
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rd_chk) begin
      checks++;
      if (q_ld.size() == 0) begin
        errors++;
        $display("FAIL out_underflow: sampled DataOut=%h AddrErr=%b Busy=%b with nothing expected", DataOut, AddrErr, Busy);
      end else begin
        exp_t e;
        e = q_ld.pop_front();
        if (DataOut !== e.data || AddrErr !== e.err || Busy !== e.busy) begin
          errors++;
          $display("FAIL %s: got DataOut=%h AddrErr=%b Busy=%b, expected DataOut=%h AddrErr=%b Busy=%b",
                   e.name, DataOut, AddrErr, Busy, e.data, e.err, e.busy);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (dut.w_commit === 1'b1) begin
      checks++;
      if (q_tr.size() == 0) begin
        errors++;
        $display("FAIL unexpected_commit: @%h: *%h <= %h", PC, {Addr[31:2], 2'b00}, dut.w_wdata);
      end else begin
        trc_t t;
        t = q_tr.pop_front();
        if (PC !== t.pc || {Addr[31:2], 2'b00} !== t.addr || dut.w_wdata !== t.word) begin
          errors++;
          $display("FAIL %s: got @%h: *%h <= %h, expected @%h: *%h <= %h", t.name,
                   PC, {Addr[31:2], 2'b00}, dut.w_wdata, t.pc, t.addr, t.word);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    rd_chk = 1'b0;
  endtask

  task automatic expect_out(input string nm, input logic [31:0] d, input logic e, input logic b);
    exp_t x;
    x.name = nm; x.data = d; x.err = e; x.busy = b;
    q_ld.push_back(x);
    rd_chk = 1'b1;
  endtask

  task automatic ld(input string nm, input logic [31:0] a, input logic [2:0] op,
                    input logic [31:0] d, input logic e);
    Addr = a; MemOp = op; MemWrite = 1'b0;
    expect_out(nm, d, e, 1'b0);
    tick();
  endtask

  task automatic st(input string nm, input logic [31:0] pc, input logic [31:0] a, input logic [2:0] op,
                    input logic [31:0] din, input logic commit, input logic [31:0] word,
                    input logic [31:0] old_out, input logic e);
    trc_t t;
    Addr = a; MemOp = op; DataIn = din; PC = pc; MemWrite = 1'b1;
    if (commit) begin
      t.name = nm; t.pc = pc; t.addr = {a[31:2], 2'b00}; t.word = word;
      q_tr.push_back(t);
    end
    expect_out(nm, old_out, e, 1'b0);
    tick();
    MemWrite = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0; rd_chk = 1'b0;
    reset = 1'b1; Addr = 32'h0; DataIn = 32'h0; MemWrite = 1'b0; MemOp = 3'b000; PC = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    expect_out("rst_busy", 32'h0, 1'b0, 1'b1);
    tick();
    for (int i = 1; i <= 16; i++) begin
      expect_out($sformatf("sweep_busy_e%0d", i), 32'h0, 1'b0, (i < 16));
      tick();
    end
    for (int w = 0; w < 16; w++) ld($sformatf("zero_w%0d", w), 32'(w * 4), 3'b000, 32'h0, 1'b0);

    st("sw_10", 32'h3000, 32'h10, 3'b000, 32'h12345678, 1'b1, 32'h12345678, 32'h0, 1'b0);
    ld("lw_10", 32'h10, 3'b000, 32'h12345678, 1'b0);
    st("sb_11", 32'h3004, 32'h11, 3'b011, 32'hCDCDCDAB, 1'b1, 32'h1234AB78, 32'h00000056, 1'b0);
    ld("lw_after_sb", 32'h10, 3'b000, 32'h1234AB78, 1'b0);
    st("sh_12", 32'h3008, 32'h12, 3'b010, 32'h1111BEEF, 1'b1, 32'hBEEFAB78, 32'h00001234, 1'b0);
    ld("lw_after_sh", 32'h10, 3'b000, 32'hBEEFAB78, 1'b0);
    ld("lb_11",  32'h11, 3'b100, 32'hFFFFFFAB, 1'b0);
    ld("lbu_11", 32'h11, 3'b011, 32'h000000AB, 1'b0);
    ld("lh_12",  32'h12, 3'b010, 32'hFFFFBEEF, 1'b0);
    ld("lhu_12", 32'h12, 3'b001, 32'h0000BEEF, 1'b0);
    ld("lb_13",  32'h13, 3'b100, 32'hFFFFFFBE, 1'b0);
    ld("lbu_10", 32'h10, 3'b011, 32'h00000078, 1'b0);
    ld("lh_10",  32'h10, 3'b010, 32'hFFFFAB78, 1'b0);

    st("sw_misalign", 32'h300C, 32'h12, 3'b000, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0, 1'b1);
    ld("lw_after_bad_sw", 32'h10, 3'b000, 32'hBEEFAB78, 1'b0);
    ld("lh_13_err", 32'h13, 3'b010, 32'h0, 1'b1);
    ld("oor_40", 32'h40, 3'b000, 32'h0, 1'b1);
    ld("oor_high", 32'h80000000, 3'b011, 32'h0, 1'b1);
    st("sw_oor_alias", 32'h3010, 32'h40, 3'b000, 32'h55555555, 1'b0, 32'h0, 32'h0, 1'b1);
    ld("lw_0_after_oor", 32'h0, 3'b000, 32'h0, 1'b0);
    ld("op110_err", 32'h10, 3'b110, 32'h0, 1'b1);
    st("op101_store", 32'h3014, 32'h10, 3'b101, 32'h66666666, 1'b0, 32'h0, 32'h0, 1'b1);
    ld("lw_after_op101", 32'h10, 3'b000, 32'hBEEFAB78, 1'b0);
    st("sw_3c", 32'h3018, 32'h3C, 3'b000, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D, 32'h0, 1'b0);
    st("sb_3f", 32'h301C, 32'h3F, 3'b100, 32'h0000005A, 1'b1, 32'h5AFEF00D, 32'hFFFFFFCA, 1'b0);
    ld("lw_3c", 32'h3C, 3'b000, 32'h5AFEF00D, 1'b0);

    reset = 1'b1;
    expect_out("rst2_busy", 32'h0, 1'b0, 1'b1);
    tick();
    reset = 1'b0;
    Addr = 32'h0; MemOp = 3'b000; DataIn = 32'hFFFFFFFF; PC = 32'h4000; MemWrite = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      expect_out($sformatf("busy_sw_e%0d", i), 32'h0, 1'b0, 1'b1);
      tick();
    end
    MemWrite = 1'b0;
    reset = 1'b1;
    expect_out("rst3_busy", 32'h0, 1'b0, 1'b1);
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      expect_out($sformatf("resweep_busy_e%0d", i), 32'h0, 1'b0, 1'b1);
      tick();
    end
    expect_out("resweep_done", 32'h0, 1'b0, 1'b0);
    tick();
    ld("lw_0_cleared",  32'h0,  3'b000, 32'h0, 1'b0);
    ld("lw_10_cleared", 32'h10, 3'b000, 32'h0, 1'b0);
    ld("lw_3c_cleared", 32'h3C, 3'b000, 32'h0, 1'b0);
    tick();

    checks++;
    if (q_ld.size() != 0) begin
      errors++;
      $display("FAIL out_queue_drain: %0d left, expected 0", q_ld.size());
    end
    checks++;
    if (q_tr.size() != 0) begin
      errors++;
      $display("FAIL trace_queue_drain: %0d commits missing, expected 0", q_tr.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
